// File: rtl/cmd_host_ctrl_if.sv
// Command / serializer / response bus between a host and cmd_host_ctrl.
// slave is the controller's view, master is the driving side.
interface cmd_host_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int Addr_size  = 4
);
  logic                    CMD_VALID;
  logic [1:0]              CMD_TYPE;
  logic [Addr_size-1:0]    CMD_ADDR;
  logic [DATA_WIDTH-1:0]   CMD_OP_A;
  logic [DATA_WIDTH-1:0]   CMD_OP_B;
  logic [3:0]              CMD_FUN;
  logic                    CMD_READY;
  logic [DATA_WIDTH-1:0]   TX_P_Data;
  logic                    TX_D_VLD;
  logic                    TX_READY;
  logic [DATA_WIDTH-1:0]   RX_P_Data;
  logic                    RX_D_VLD;
  logic [2*DATA_WIDTH-1:0] RSP_DATA;
  logic                    RSP_VALID;
  logic                    RSP_ERR;

  modport slave (
    input  CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_OP_A, CMD_OP_B, CMD_FUN,
    input  TX_READY, RX_P_Data, RX_D_VLD,
    output CMD_READY, TX_P_Data, TX_D_VLD, RSP_DATA, RSP_VALID, RSP_ERR
  );

  modport master (
    output CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_OP_A, CMD_OP_B, CMD_FUN,
    output TX_READY, RX_P_Data, RX_D_VLD,
    input  CMD_READY, TX_P_Data, TX_D_VLD, RSP_DATA, RSP_VALID, RSP_ERR
  );
endinterface

// File: rtl/cmd_host_ctrl.sv
// Command host controller: frames a command to a byte serializer and assembles the reply.
// Optional response timeout enabled by defining CMD_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a command, CMD_READY high
// SEND    | presenting frame byte idx until the serializer takes it
// WAIT_LO | waiting for the first (or only) response byte
// WAIT_HI | waiting for the high response byte of an ALU command
module cmd_host_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int Addr_size      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic            CLK,
  input logic            RST,
  cmd_host_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_LO, WAIT_HI} state_t;

  localparam logic [1:0] T_AA = 2'd0;
  localparam logic [1:0] T_BB = 2'd1;
  localparam logic [1:0] T_CC = 2'd2;

  state_t                  state, state_nxt;
  logic [1:0]              idx, idx_nxt;
  logic [1:0]              typ_q;
  logic [Addr_size-1:0]    addr_q;
  logic [DATA_WIDTH-1:0]   a_q, b_q;
  logic [3:0]              fun_q;
  logic                    cap;
  logic                    tx_vld, tx_vld_nxt;
  logic [DATA_WIDTH-1:0]   tx_data, tx_data_nxt;
  logic [DATA_WIDTH-1:0]   lo_q, lo_nxt;
  logic [2*DATA_WIDTH-1:0] rsp_data, rsp_data_nxt;
  logic                    rsp_valid, rsp_valid_nxt;

  function automatic logic [DATA_WIDTH-1:0] frame_byte(
    input logic [1:0]            t,
    input logic [1:0]            i,
    input logic [Addr_size-1:0]  ad,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [3:0]            f
  );
    logic [DATA_WIDTH-1:0] ad_x, f_x, hdr;
    ad_x = DATA_WIDTH'(ad);
    f_x  = DATA_WIDTH'(f);
    case (t)
      2'd0:    hdr = DATA_WIDTH'(8'hAA);
      2'd1:    hdr = DATA_WIDTH'(8'hBB);
      2'd2:    hdr = DATA_WIDTH'(8'hCC);
      default: hdr = DATA_WIDTH'(8'hDD);
    endcase
    frame_byte = hdr;
    if (i != 2'd0) begin
      case (t)
        2'd0:    frame_byte = (i == 2'd1) ? ad_x : a;
        2'd1:    frame_byte = ad_x;
        2'd2:    frame_byte = (i == 2'd1) ? a : ((i == 2'd2) ? b : f_x);
        default: frame_byte = f_x;
      endcase
    end
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] t);
    case (t)
      2'd0:    last_idx = 2'd2;
      2'd2:    last_idx = 2'd3;
      default: last_idx = 2'd1;
    endcase
  endfunction

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_wait, tmo_hit;
  logic          rsp_err, rsp_err_nxt;

  assign in_wait = (state == WAIT_LO) || (state == WAIT_HI);
  assign tmo_hit = in_wait && (tmo_cnt == TC_LAST);

  // Counter idles at zero, so entering a wait state starts it from a clean count.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_err <= rsp_err_nxt;
      if (!in_wait || bus.RX_D_VLD || tmo_hit) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign bus.RSP_ERR = rsp_err;
`else
  logic unused_tmo;
  assign unused_tmo  = |TIMEOUT_CYCLES;
  assign bus.RSP_ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      idx       <= 2'd0;
      typ_q     <= 2'd0;
      addr_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      fun_q     <= 4'd0;
      tx_vld    <= 1'b0;
      tx_data   <= '0;
      lo_q      <= '0;
      rsp_data  <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      tx_vld    <= tx_vld_nxt;
      tx_data   <= tx_data_nxt;
      lo_q      <= lo_nxt;
      rsp_data  <= rsp_data_nxt;
      rsp_valid <= rsp_valid_nxt;
      if (cap) begin
        typ_q  <= bus.CMD_TYPE;
        addr_q <= bus.CMD_ADDR;
        a_q    <= bus.CMD_OP_A;
        b_q    <= bus.CMD_OP_B;
        fun_q  <= bus.CMD_FUN;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    cap           = 1'b0;
    tx_vld_nxt    = tx_vld;
    tx_data_nxt   = tx_data;
    lo_nxt        = lo_q;
    rsp_data_nxt  = rsp_data;
    rsp_valid_nxt = 1'b0;
`ifdef CMD_TIMEOUT_EN
    rsp_err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.CMD_VALID) begin
          cap         = 1'b1;
          state_nxt   = SEND;
          idx_nxt     = 2'd0;
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = frame_byte(bus.CMD_TYPE, 2'd0, bus.CMD_ADDR,
                                   bus.CMD_OP_A, bus.CMD_OP_B, bus.CMD_FUN);
        end
      end
      SEND: begin
        if (bus.TX_READY) begin
          if (idx == last_idx(typ_q)) begin
            tx_vld_nxt = 1'b0;
            if (typ_q == T_AA) begin
              state_nxt     = IDLE;
              rsp_data_nxt  = '0;
              rsp_valid_nxt = 1'b1;
            end else begin
              state_nxt = WAIT_LO;
            end
          end else begin
            idx_nxt     = idx + 2'd1;
            tx_data_nxt = frame_byte(typ_q, idx + 2'd1, addr_q, a_q, b_q, fun_q);
          end
        end
      end
      WAIT_LO: begin
        if (bus.RX_D_VLD) begin
          if (typ_q == T_BB) begin
            state_nxt     = IDLE;
            rsp_data_nxt  = {{DATA_WIDTH{1'b0}}, bus.RX_P_Data};
            rsp_valid_nxt = 1'b1;
          end else begin
            lo_nxt    = bus.RX_P_Data;
            state_nxt = WAIT_HI;
          end
        end
`ifdef CMD_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt   = IDLE;
          rsp_err_nxt = 1'b1;
        end
`endif
      end
      WAIT_HI: begin
        if (bus.RX_D_VLD) begin
          state_nxt     = IDLE;
          rsp_data_nxt  = {bus.RX_P_Data, lo_q};
          rsp_valid_nxt = 1'b1;
        end
`ifdef CMD_TIMEOUT_EN
        else if (tmo_hit) begin
          state_nxt   = IDLE;
          rsp_err_nxt = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.CMD_READY = (state == IDLE);
  assign bus.TX_D_VLD  = tx_vld;
  assign bus.TX_P_Data = tx_data;
  assign bus.RSP_DATA  = rsp_data;
  assign bus.RSP_VALID = rsp_valid;

  logic unused_cc;
  assign unused_cc = ^T_CC;

endmodule

// File: tb/tb_cmd_host_ctrl.sv
// Self-checking bench for cmd_host_ctrl: directed vector table, random commands
// against a frame/response model, plus reset-abort and timeout sequences.
module tb_cmd_host_ctrl;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int TMO = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  cmd_host_ctrl_if #(.DATA_WIDTH(DW), .Addr_size(AW)) bus ();

  cmd_host_ctrl #(.DATA_WIDTH(DW), .Addr_size(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [2*DW-1:0] last_rsp = '0;

  typedef struct {
    logic [1:0]      t;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [3:0]      fun;
    int              stall;
    logic [DW-1:0]   rx0;
    logic [DW-1:0]   rx1;
    int              n;
    logic [3:0][7:0] exp_b;
    logic [15:0]     exp_rsp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] t, input logic [3:0] ad, input logic [7:0] a,
                              input logic [7:0] b, input logic [3:0] f, input int st,
                              input logic [7:0] r0, input logic [7:0] r1, input int n,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic [7:0] e3, input logic [15:0] er);
    vec_t v;
    v.t = t; v.addr = ad; v.a = a; v.b = b; v.fun = f; v.stall = st;
    v.rx0 = r0; v.rx1 = r1; v.n = n;
    v.exp_b[0] = e0; v.exp_b[1] = e1; v.exp_b[2] = e2; v.exp_b[3] = e3;
    v.exp_rsp = er;
    return v;
  endfunction

  // Reference: frame layout and response assembly straight from the command rules.
  function automatic void model(inout vec_t v);
    logic [7:0] q[$];
    q.delete();
    case (v.t)
      2'd0: begin q.push_back(8'hAA); q.push_back({4'h0, v.addr}); q.push_back(v.a); end
      2'd1: begin q.push_back(8'hBB); q.push_back({4'h0, v.addr}); end
      2'd2: begin q.push_back(8'hCC); q.push_back(v.a); q.push_back(v.b); q.push_back({4'h0, v.fun}); end
      default: begin q.push_back(8'hDD); q.push_back({4'h0, v.fun}); end
    endcase
    v.n = q.size();
    v.exp_b = '0;
    foreach (q[i]) v.exp_b[i] = q[i];
    case (v.t)
      2'd0:    v.exp_rsp = 16'h0000;
      2'd1:    v.exp_rsp = {8'h00, v.rx0};
      default: v.exp_rsp = {v.rx1, v.rx0};
    endcase
  endfunction

  task automatic drive_cmd(input vec_t v);
    bus.CMD_VALID = 1'b1;
    bus.CMD_TYPE  = v.t;
    bus.CMD_ADDR  = v.addr;
    bus.CMD_OP_A  = v.a;
    bus.CMD_OP_B  = v.b;
    bus.CMD_FUN   = v.fun;
    @(posedge CLK);
    @(negedge CLK);
    bus.CMD_VALID = 1'b0;
    bus.CMD_TYPE  = 2'($urandom);
    bus.CMD_ADDR  = 4'($urandom);
    bus.CMD_OP_A  = 8'($urandom);
    bus.CMD_OP_B  = 8'($urandom);
    bus.CMD_FUN   = 4'($urandom);
  endtask

  task automatic do_cmd(input vec_t v, input int gap, input bit inject);
    int nrx;
    // A stray response strobe while idle must change nothing.
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b1;
    bus.RX_P_Data = 8'($urandom);
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
    chk("idle_rx_valid", bus.RSP_VALID, 0);
    chk("idle_rx_hold", bus.RSP_DATA, last_rsp);
    chk("idle_ready", bus.CMD_READY, 1);
    drive_cmd(v);
    chk("busy_ready", bus.CMD_READY, 0);
    for (int i = 0; i < v.n; i++) begin
      for (int s = 0; s <= v.stall; s++) begin
        chk("tx_vld", bus.TX_D_VLD, 1);
        chk("tx_byte", bus.TX_P_Data, v.exp_b[i]);
        if (inject && i == 0 && s == 0) begin
          bus.RX_D_VLD  = 1'b1;
          bus.RX_P_Data = 8'($urandom);
        end
        bus.TX_READY = (s == v.stall);
        @(negedge CLK);
        bus.RX_D_VLD = 1'b0;
      end
    end
    bus.TX_READY = 1'b0;
    chk("tx_vld_end", bus.TX_D_VLD, 0);
    if (v.t == 2'd0) begin
      chk("aa_rsp_valid", bus.RSP_VALID, 1);
    end else begin
      chk("wait_rsp_valid", bus.RSP_VALID, 0);
      chk("wait_ready", bus.CMD_READY, 0);
      nrx = (v.t == 2'd1) ? 1 : 2;
      for (int k = 0; k < nrx; k++) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge CLK);
          chk("gap_rsp_valid", bus.RSP_VALID, 0);
          chk("gap_rsp_err", bus.RSP_ERR, 0);
        end
        bus.RX_D_VLD  = 1'b1;
        bus.RX_P_Data = (k == 0) ? v.rx0 : v.rx1;
        @(negedge CLK);
        bus.RX_D_VLD  = 1'b0;
        if (k < nrx - 1) begin
          chk("lo_rsp_valid", bus.RSP_VALID, 0);
          chk("lo_ready", bus.CMD_READY, 0);
        end
      end
      chk("rsp_valid", bus.RSP_VALID, 1);
    end
    chk("rsp_data", bus.RSP_DATA, v.exp_rsp);
    chk("done_ready", bus.CMD_READY, 1);
    chk("done_err", bus.RSP_ERR, 0);
    last_rsp = v.exp_rsp;
    @(negedge CLK);
    chk("rsp_pulse_len", bus.RSP_VALID, 0);
    chk("rsp_hold", bus.RSP_DATA, last_rsp);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.CMD_VALID = 1'b0; bus.CMD_TYPE = '0; bus.CMD_ADDR = '0;
    bus.CMD_OP_A = '0; bus.CMD_OP_B = '0; bus.CMD_FUN = '0;
    bus.TX_READY = 1'b0; bus.RX_P_Data = '0; bus.RX_D_VLD = 1'b0;

    vecs[0] = mk(2'd0, 4'd5, 8'h3C, 8'h00, 4'd0, 0, 8'h00, 8'h00, 3, 8'hAA, 8'h05, 8'h3C, 8'h00, 16'h0000);
    vecs[1] = mk(2'd1, 4'd2, 8'h00, 8'h00, 4'd0, 3, 8'h7E, 8'h00, 2, 8'hBB, 8'h02, 8'h00, 8'h00, 16'h007E);
    vecs[2] = mk(2'd2, 4'd0, 8'h10, 8'h20, 4'd1, 0, 8'h34, 8'h12, 4, 8'hCC, 8'h10, 8'h20, 8'h01, 16'h1234);
    vecs[3] = mk(2'd3, 4'd0, 8'h00, 8'h00, 4'd3, 1, 8'h55, 8'hAA, 2, 8'hDD, 8'h03, 8'h00, 8'h00, 16'hAA55);
    vecs[4] = mk(2'd1, 4'hF, 8'h00, 8'h00, 4'd0, 0, 8'h01, 8'h00, 2, 8'hBB, 8'h0F, 8'h00, 8'h00, 16'h0001);

    repeat (3) @(negedge CLK);
    chk("rst_ready", bus.CMD_READY, 1);
    chk("rst_tx_vld", bus.TX_D_VLD, 0);
    chk("rst_tx_data", bus.TX_P_Data, 0);
    chk("rst_rsp_data", bus.RSP_DATA, 0);
    chk("rst_rsp_valid", bus.RSP_VALID, 0);
    chk("rst_rsp_err", bus.RSP_ERR, 0);
    RST = 1'b1;

    foreach (vecs[i]) do_cmd(vecs[i], 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      rv.t     = 2'($urandom);
      rv.addr  = 4'($urandom);
      rv.a     = 8'($urandom);
      rv.b     = 8'($urandom);
      rv.fun   = 4'($urandom);
      rv.stall = $urandom_range(0, 2);
      rv.rx0   = 8'($urandom);
      rv.rx1   = 8'($urandom);
      model(rv);
      do_cmd(rv, $urandom_range(0, 8), 1'($urandom));
    end

`ifndef CMD_TIMEOUT_EN
    // Without the timeout the wait is unbounded and RSP_ERR never fires.
    do_cmd(mk(2'd1, 4'd9, 8'h00, 8'h00, 4'd0, 0, 8'hC3, 8'h00, 2, 8'hBB, 8'h09, 8'h00, 8'h00, 16'h00C3), 40, 1'b0);
`else
    // DD with no reply: RSP_ERR exactly TMO cycles after entering WAIT_LO.
    drive_cmd(mk(2'd3, 4'd0, 8'h00, 8'h00, 4'd3, 0, 8'h00, 8'h00, 2, 8'hDD, 8'h03, 8'h00, 8'h00, 16'h0000));
    bus.TX_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.TX_READY = 1'b0;
    chk("tmo_tx_vld", bus.TX_D_VLD, 0);
    for (int k = 1; k <= TMO; k++) begin
      @(negedge CLK);
      chk("tmo_err", bus.RSP_ERR, (k == TMO) ? 1 : 0);
      chk("tmo_valid", bus.RSP_VALID, 0);
    end
    chk("tmo_ready", bus.CMD_READY, 1);
    chk("tmo_data_hold", bus.RSP_DATA, last_rsp);
    @(negedge CLK);
    chk("tmo_err_len", bus.RSP_ERR, 0);
`endif

    // CC with a strobe during SEND, then reset while in WAIT_HI.
    drive_cmd(vecs[2]);
    bus.RX_D_VLD  = 1'b1;
    bus.RX_P_Data = 8'h99;
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
    chk("send_rx_vld", bus.TX_D_VLD, 1);
    chk("send_rx_byte", bus.TX_P_Data, 8'hCC);
    bus.TX_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_tx_byte", bus.TX_P_Data, vecs[2].exp_b[i]);
      @(negedge CLK);
    end
    bus.TX_READY  = 1'b0;
    bus.RX_D_VLD  = 1'b1;
    bus.RX_P_Data = 8'h34;
    @(negedge CLK);
    bus.RX_D_VLD  = 1'b0;
    chk("abort_in_wait", bus.CMD_READY, 0);
    RST = 1'b0;
    #1;
    chk("abort_ready", bus.CMD_READY, 1);
    chk("abort_tx_vld", bus.TX_D_VLD, 0);
    chk("abort_tx_data", bus.TX_P_Data, 0);
    chk("abort_rsp_data", bus.RSP_DATA, 0);
    chk("abort_rsp_valid", bus.RSP_VALID, 0);
    chk("abort_rsp_err", bus.RSP_ERR, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    last_rsp = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("post_rst_valid", bus.RSP_VALID, 0);
      chk("post_rst_err", bus.RSP_ERR, 0);
    end
    do_cmd(vecs[3], 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
